// File: rtl/br_resolve_if.sv
// ---------------------------------------------------------------------------
// br_resolve_if
// Groups the EX-stage signals exchanged between the pipeline/comparator and
// the branch resolver into one bundle.
//
// Signal directions are named from br_resolve's point of view (_i = into the
// resolver, _o = out of the resolver).
//   ex_valid_i       EX holds a valid instruction
//   ex_is_branch_i   EX instruction is a conditional branch
//   ex_is_jump_i     EX instruction is JAL/JALR
//   ex_funct3_i      branch funct3
//   ex_pc_i          PC of the EX instruction
//   ex_target_i      computed branch/jump target
//   ex_pred_taken_i  prediction carried down the pipe with the instruction
//   br_less_i        comparator result: rs1 < rs2
//   br_equal_i       comparator result: rs1 == rs2
//   br_unsigned_o    comparator mode select (combinational)
//   redirect_o       registered one-cycle redirect pulse
//   redirect_pc_o    registered redirect target
//   flush_o          squash IF/ID and the next EX slot (= redirect_o)
//   illegal_br_o     registered pulse: branch with funct3 010/011
//
// Modports:
//   master : pipeline / comparator side
//   slave  : br_resolve
// ---------------------------------------------------------------------------
interface br_resolve_if #(
   parameter int XLEN = 32
);
   logic            ex_valid_i;
   logic            ex_is_branch_i;
   logic            ex_is_jump_i;
   logic [2:0]      ex_funct3_i;
   logic [XLEN-1:0] ex_pc_i;
   logic [XLEN-1:0] ex_target_i;
   logic            ex_pred_taken_i;
   logic            br_less_i;
   logic            br_equal_i;
   logic            br_unsigned_o;
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            flush_o;
   logic            illegal_br_o;

   modport master (
      output ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_funct3_i,
             ex_pc_i, ex_target_i, ex_pred_taken_i, br_less_i, br_equal_i,
      input  br_unsigned_o, redirect_o, redirect_pc_o, flush_o, illegal_br_o
   );

   modport slave (
      input  ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_funct3_i,
             ex_pc_i, ex_target_i, ex_pred_taken_i, br_less_i, br_equal_i,
      output br_unsigned_o, redirect_o, redirect_pc_o, flush_o, illegal_br_o
   );
endinterface

// File: rtl/br_resolve.sv
// ---------------------------------------------------------------------------
// br_resolve
// EX-stage consumer of the branch comparator:
//   - selects signed/unsigned compare mode for the comparator,
//   - decodes the taken decision from br_less/br_equal and funct3,
//   - checks it against the fetch-time prediction and issues a registered
//     redirect/flush on a mispredict,
//   - owns the 2-bit saturating branch history table (BHT) used by fetch.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous reset, active-high
//   if_pc_i          fetch PC for BHT lookup
//   if_pred_taken_o  prediction for if_pc_i (combinational read)
//   ex               br_resolve_if.slave EX/comparator/redirect bundle
//   branch_cnt_o     resolved legal conditional branches (statistics)
//   mispred_cnt_o    mispredicted branches + jumps (statistics)
//
// Optional feature: define BR_STATS_EN to build the two 32-bit statistics
// counters. Without it both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module br_resolve #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] if_pc_i,
   output logic            if_pred_taken_o,
   br_resolve_if.slave     ex,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     mispred_cnt_o
);
   localparam int IDXW = $clog2(BHT_ENTRIES);

   // Registered outputs
   logic            redirect_q,    redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            illegal_q,     illegal_d;

   // Resolve-side decode
   logic            res;
   logic            f3_illegal;
   logic            cond_true;
   logic            taken;
   logic            mispred;
   logic            bht_we;
   logic [1:0]      bht_old;
   logic [1:0]      bht_new;

   logic [IDXW-1:0] if_idx;
   logic [IDXW-1:0] ex_idx;
   logic [1:0]      bht_rd [BHT_ENTRIES];

   // PC bits outside the BHT index field do not take part in the lookup.
   logic            unused_if_pc;
   assign unused_if_pc = ^{if_pc_i[XLEN-1:IDXW+2], if_pc_i[1:0]};

   assign if_idx = if_pc_i[IDXW+1:2];
   assign ex_idx = ex.ex_pc_i[IDXW+1:2];

   // funct3[1] separates BLTU/BGEU from the signed compares.
   assign ex.br_unsigned_o = ex.ex_funct3_i[1];

   always_comb begin
      cond_true  = 1'b0;
      f3_illegal = 1'b0;
      unique case (ex.ex_funct3_i)
         3'b000:          cond_true  = ex.br_equal_i;
         3'b001:          cond_true  = ~ex.br_equal_i;
         3'b100, 3'b110:  cond_true  = ex.br_less_i;
         3'b101, 3'b111:  cond_true  = ~ex.br_less_i;
         default:         f3_illegal = 1'b1;   // 010 / 011
      endcase
   end

   always_comb begin
      // The slot right after a redirect carries a wrong-path instruction.
      res     = ex.ex_valid_i & ~redirect_q & (ex.ex_is_branch_i | ex.ex_is_jump_i);
      taken   = ex.ex_is_jump_i | (~f3_illegal & cond_true);
      mispred = res & (taken != ex.ex_pred_taken_i);
      // Jumps and illegal encodings never train the predictor.
      bht_we  = res & ex.ex_is_branch_i & ~ex.ex_is_jump_i & ~f3_illegal;

      illegal_d     = res & ex.ex_is_branch_i & ~ex.ex_is_jump_i & f3_illegal;
      redirect_d    = mispred;
      redirect_pc_d = redirect_pc_q;
      if (mispred) begin
         redirect_pc_d = taken ? ex.ex_target_i : (ex.ex_pc_i + XLEN'(4));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         illegal_q     <= illegal_d;
      end
   end

   assign ex.redirect_o    = redirect_q;
   assign ex.redirect_pc_o = redirect_pc_q;
   assign ex.flush_o       = redirect_q;
   assign ex.illegal_br_o  = illegal_q;

   // ------------------------------------------------------------------
   // BHT: one 2-bit saturating counter per entry. Each entry is its own
   // flop pair so the whole table can be cleared by the async reset and
   // read combinationally by fetch. A write lands at the clock edge, so
   // a same-cycle lookup of the written index sees the old value.
   // ------------------------------------------------------------------
   assign bht_old = bht_rd[ex_idx];

   always_comb begin
      bht_new = bht_old;
      if (taken) begin
         if (bht_old != 2'b11) bht_new = bht_old + 2'b01;
      end else begin
         if (bht_old != 2'b00) bht_new = bht_old - 2'b01;
      end
   end

   for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] ctr_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            ctr_q <= 2'b01;                     // weakly not-taken
         end else if (bht_we && (ex_idx == IDXW'(gi))) begin
            ctr_q <= bht_new;
         end
      end

      assign bht_rd[gi] = ctr_q;
   end

   assign if_pred_taken_o = bht_rd[if_idx][1];

   // ------------------------------------------------------------------
   // Statistics counters
   // ------------------------------------------------------------------
`ifdef BR_STATS_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      branch_cnt_d  = branch_cnt_q  + {31'd0, bht_we};
      mispred_cnt_d = mispred_cnt_q + {31'd0, mispred};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`else
   assign branch_cnt_o  = 32'd0;
   assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// ---------------------------------------------------------------------------
// tb_br_resolve
// Directed testbench for br_resolve. A behavioural model (BHT as an integer
// array, redirect/illegal/counter expectations) is updated at each clock
// edge from the resolution rules; one compare process checks every DUT
// output against it on each falling edge. Literal checks in the stimulus
// sequence pin both the DUT and the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_br_resolve;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred;
   logic [31:0] bcnt;
   logic [31:0] mcnt;

   int checks = 0;
   int errors = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   br_resolve_if #(.XLEN(32)) bus ();

   br_resolve #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .if_pc_i         (if_pc),
      .if_pred_taken_o (if_pred),
      .ex              (bus.slave),
      .branch_cnt_o    (bcnt),
      .mispred_cnt_o   (mcnt)
   );

   // ---------------- behavioural model ----------------
   int          m_bht [64];
   logic        m_redir;
   logic [31:0] m_rpc;
   logic        m_ill;
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   function automatic logic m_taken(input logic [2:0] f3, input logic less, input logic eq);
      case (f3)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return less;
         3'd5, 3'd7: return !less;
         default:    return 1'b0;
      endcase
   endfunction

   logic m_res, m_legal, m_tk;
   int   m_ix;
   assign m_res   = bus.ex_valid_i & ~m_redir & (bus.ex_is_branch_i | bus.ex_is_jump_i);
   assign m_legal = (bus.ex_funct3_i != 3'd2) && (bus.ex_funct3_i != 3'd3);
   assign m_tk    = bus.ex_is_jump_i ? 1'b1
                    : (m_legal & m_taken(bus.ex_funct3_i, bus.br_less_i, bus.br_equal_i));
   assign m_ix    = int'((bus.ex_pc_i >> 2) & 32'h3f);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) m_bht[i] <= 1;
         m_redir <= 1'b0;
         m_rpc   <= 32'd0;
         m_ill   <= 1'b0;
         m_bc    <= 32'd0;
         m_mc    <= 32'd0;
      end else begin
         m_ill <= m_res && bus.ex_is_branch_i && !bus.ex_is_jump_i && !m_legal;
         if (m_res && (m_tk != bus.ex_pred_taken_i)) begin
            m_redir <= 1'b1;
            m_rpc   <= m_tk ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
            m_mc    <= m_mc + 32'd1;
         end else begin
            m_redir <= 1'b0;
         end
         if (m_res && bus.ex_is_branch_i && !bus.ex_is_jump_i && m_legal) begin
            m_bht[m_ix] <= m_tk ? ((m_bht[m_ix] < 3) ? m_bht[m_ix] + 1 : 3)
                                : ((m_bht[m_ix] > 0) ? m_bht[m_ix] - 1 : 0);
            m_bc <= m_bc + 32'd1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_redirect", bus.redirect_o, m_redir);
         chk("cyc_flush", bus.flush_o, m_redir);
         chk("cyc_redirect_pc", bus.redirect_pc_o, m_rpc);
         chk("cyc_illegal", bus.illegal_br_o, m_ill);
         chk("cyc_unsigned", bus.br_unsigned_o, bus.ex_funct3_i[1]);
         chk("cyc_pred", if_pred, m_bht[int'((if_pc >> 2) & 32'h3f)] >= 2);
`ifdef BR_STATS_EN
         chk("cyc_branch_cnt", bcnt, m_bc);
         chk("cyc_mispred_cnt", mcnt, m_mc);
`else
         chk("cyc_branch_cnt", bcnt, 0);
         chk("cyc_mispred_cnt", mcnt, 0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic setx(input string nm, input logic v, input logic br, input logic jp,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pr, input logic ls, input logic eq);
      bus.ex_valid_i      = v;
      bus.ex_is_branch_i  = br;
      bus.ex_is_jump_i    = jp;
      bus.ex_funct3_i     = f3;
      bus.ex_pc_i         = pc;
      bus.ex_target_i     = tgt;
      bus.ex_pred_taken_i = pr;
      bus.br_less_i       = ls;
      bus.br_equal_i      = eq;
      if_pc               = pc;
      $display("TXN %-8s v=%0b br=%0b jp=%0b f3=%0d pc=%08h tgt=%08h pred=%0b less=%0b eq=%0b",
               nm, v, br, jp, f3, pc, tgt, pr, ls, eq);
   endtask

   task automatic idle();
      bus.ex_valid_i     = 1'b0;
      bus.ex_is_branch_i = 1'b0;
      bus.ex_is_jump_i   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      setx("IDLE", 0, 0, 0, 3'd0, 32'h100, 32'h0, 0, 0, 0);
      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_pred", if_pred, 0);
      chk("rst_redirect", bus.redirect_o, 0);
      chk("rst_model_bht", m_bht[5], 1);
      rst = 1'b0;

      // BLT taken, predicted not-taken -> redirect to target
      setx("BLT", 1, 1, 0, 3'b100, 32'h100, 32'h80, 0, 1, 0);
      #1 chk("blt_unsigned", bus.br_unsigned_o, 0);
      tick();
      chk("blt_redirect", bus.redirect_o, 1);
      chk("blt_redirect_pc", bus.redirect_pc_o, 32'h80);
      chk("blt_model_bht", m_bht[0], 2);
      chk("blt_pred_after", if_pred, 1);
      idle(); tick();

      // BGEU taken, predicted taken -> no redirect
      setx("BGEU", 1, 1, 0, 3'b111, 32'h304, 32'h400, 1, 0, 0);
      #1 chk("bgeu_unsigned", bus.br_unsigned_o, 1);
      tick();
      chk("bgeu_no_redirect", bus.redirect_o, 0);
      chk("bgeu_pred_after", if_pred, 1);

      // BNE not taken, predicted taken -> redirect to pc+4
      setx("BNE", 1, 1, 0, 3'b001, 32'h200, 32'h300, 1, 0, 1);
      tick();
      chk("bne_redirect", bus.redirect_o, 1);
      chk("bne_redirect_pc", bus.redirect_pc_o, 32'h204);
      // Wrong-path branch in the shadow slot must be ignored
      setx("SHADOW", 1, 1, 0, 3'b000, 32'h208, 32'h500, 0, 0, 1);
      tick();
      chk("shadow_no_redirect", bus.redirect_o, 0);
      chk("shadow_pc_hold", bus.redirect_pc_o, 32'h204);
      chk("shadow_pred", if_pred, 0);
      idle(); tick();

      // Train one PC four times taken, then once not-taken
      for (int i = 0; i < 4; i++) begin
         setx("TRAIN_T", 1, 1, 0, 3'b000, 32'h40, 32'h10, 1, 0, 1);
         tick();
      end
      chk("train_sat_model", m_bht[16], 3);
      chk("train_sat_pred", if_pred, 1);
      setx("TRAIN_N", 1, 1, 0, 3'b000, 32'h40, 32'h10, 0, 0, 0);
      tick();
      chk("train_dec_model", m_bht[16], 2);
      chk("train_dec_pred", if_pred, 1);
      chk("train_no_redirect", bus.redirect_o, 0);

      // Illegal funct3
      setx("ILL010", 1, 1, 0, 3'b010, 32'h44, 32'h90, 0, 1, 1);
      tick();
      chk("ill_pulse", bus.illegal_br_o, 1);
      chk("ill_no_redirect", bus.redirect_o, 0);
      chk("ill_model_bht", m_bht[17], 1);
      idle(); tick();
      chk("ill_pulse_end", bus.illegal_br_o, 0);

      // Jump predicted not-taken -> redirect to target
      setx("JAL", 1, 0, 1, 3'b000, 32'h500, 32'h1000, 0, 0, 0);
      tick();
      chk("jal_redirect", bus.redirect_o, 1);
      chk("jal_redirect_pc", bus.redirect_pc_o, 32'h1000);
      idle(); tick();

      // pc+4 wraps modulo 2^32
      setx("BEQWRAP", 1, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h20, 1, 0, 0);
      tick();
      chk("wrap_redirect", bus.redirect_o, 1);
      chk("wrap_redirect_pc", bus.redirect_pc_o, 32'h0);
      idle(); tick();

      // Back-to-back correctly predicted branches
      setx("BLTU", 1, 1, 0, 3'b110, 32'h600, 32'h700, 1, 1, 0);
      tick();
      setx("BGE", 1, 1, 0, 3'b101, 32'h604, 32'h700, 0, 1, 0);
      tick();
      setx("BLT", 1, 1, 0, 3'b100, 32'h608, 32'h700, 0, 0, 0);
      tick();
      chk("b2b_no_redirect", bus.redirect_o, 0);
      chk("b2b_pc_hold", bus.redirect_pc_o, 32'h0);

      // Reset while a mispredict is pending
      setx("PENDING", 1, 1, 0, 3'b000, 32'h700, 32'h800, 0, 0, 1);
      #2 rst = 1'b1;
      #1 chk("midrst_redirect", bus.redirect_o, 0);
      tick();
      chk("midrst_held", bus.redirect_o, 0);
      idle();
      rst = 1'b0;
      tick();
      chk("postrst_redirect", bus.redirect_o, 0);
      if_pc = 32'h40;
      #1 chk("postrst_pred", if_pred, 0);

      // Statistics: 3 branches, 1 mispredict
      setx("ST1", 1, 1, 0, 3'b000, 32'h10, 32'h40, 1, 0, 1);
      tick();
      setx("ST2", 1, 1, 0, 3'b000, 32'h14, 32'h40, 1, 0, 1);
      tick();
      setx("ST3", 1, 1, 0, 3'b000, 32'h18, 32'h40, 1, 0, 0);
      tick();
      chk("st_redirect_pc", bus.redirect_pc_o, 32'h1c);
      idle(); tick();
`ifdef BR_STATS_EN
      chk("st_branch_cnt", bcnt, 3);
      chk("st_mispred_cnt", mcnt, 1);
`else
      chk("st_branch_cnt", bcnt, 0);
      chk("st_mispred_cnt", mcnt, 0);
`endif
      tick();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
